// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage RV32 pipeline: EX operand forwarding, load-use stalls,
// branch flushes and a pending-register scoreboard for the multi-cycle MUL/DIV unit.
module hazard_scoreboard_unit #(
  parameter int NRS      = 2,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int MAX_OUT  = 4,
  parameter int FWD_EN   = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NRS*AW-1:0]           rs_D_i,
  input  logic [NRS-1:0]              rs_used_D_i,
  input  logic [AW-1:0]               rd_D_i,
  input  logic                        regwrite_D_i,
  input  logic                        mdu_op_D_i,
  input  logic [NRS*AW-1:0]           rs_EX_i,
  input  logic [AW-1:0]               rd_EX_i,
  input  logic                        regwrite_EX_i,
  input  logic                        is_load_EX_i,
  input  logic [AW-1:0]               rd_MEM_i,
  input  logic                        regwrite_MEM_i,
  input  logic [AW-1:0]               rd_WB_i,
  input  logic                        regwrite_WB_i,
  input  logic                        pc_takenE_i,
  input  logic                        mdu_issue_i,
  input  logic [AW-1:0]               mdu_rd_i,
  input  logic                        mdu_done_i,
  input  logic [AW-1:0]               mdu_done_rd_i,
  output logic                        stallF_o,
  output logic                        stallD_o,
  output logic                        flushD_o,
  output logic                        flushE_o,
  output logic [NRS*2-1:0]            forward_o,
  output logic                        sb_busy_o,
  output logic [$clog2(MAX_OUT+1)-1:0] sb_count_o
);

  localparam int NREG = 2 ** AW;
  localparam int CW   = $clog2(MAX_OUT + 1);
  localparam int LW   = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  logic [NREG-1:0] pending_q, pending_nxt;
  logic [CW-1:0]   sb_count_q, sb_count_nxt;
  logic [LW-1:0]   ld_cnt_q;

  logic            ld_hit, fwd_stall, sb_raw, sb_waw, sb_full, stall;
  logic [NRS*2-1:0] fwd_sel;

  // True when any used decode operand reads the nonzero register rd.
  function automatic logic src_match(input logic [NRS*AW-1:0] rs,
                                     input logic [NRS-1:0]    used,
                                     input logic [AW-1:0]     rd);
    src_match = 1'b0;
    for (int k = 0; k < NRS; k++)
      if (used[k] && (rd != '0) && (rs[k*AW +: AW] == rd)) src_match = 1'b1;
  endfunction

  function automatic logic pend_match(input logic [NRS*AW-1:0] rs,
                                      input logic [NRS-1:0]    used,
                                      input logic [NREG-1:0]   pend);
    pend_match = 1'b0;
    for (int k = 0; k < NRS; k++)
      if (used[k] && pend[rs[k*AW +: AW]]) pend_match = 1'b1;
  endfunction

  function automatic logic [1:0] fwd_pick(input logic [AW-1:0] rs);
    if (regwrite_MEM_i && (rd_MEM_i != '0) && (rd_MEM_i == rs))     fwd_pick = 2'b10;
    else if (regwrite_WB_i && (rd_WB_i != '0) && (rd_WB_i == rs))   fwd_pick = 2'b01;
    else                                                            fwd_pick = 2'b00;
  endfunction

  for (genvar k = 0; k < NRS; k++) begin : g_fwd
    assign fwd_sel[2*k +: 2] = (FWD_EN != 0) ? fwd_pick(rs_EX_i[k*AW +: AW]) : 2'b00;
  end

  always_comb begin
    ld_hit    = is_load_EX_i && regwrite_EX_i && src_match(rs_D_i, rs_used_D_i, rd_EX_i);
    // Without forwarding, anything still in EX or MEM must reach the regfile first.
    fwd_stall = (FWD_EN == 0) &&
                ((regwrite_EX_i  && src_match(rs_D_i, rs_used_D_i, rd_EX_i)) ||
                 (regwrite_MEM_i && src_match(rs_D_i, rs_used_D_i, rd_MEM_i)));
    sb_raw    = pend_match(rs_D_i, rs_used_D_i, pending_q);
    sb_waw    = regwrite_D_i && (rd_D_i != '0) && pending_q[rd_D_i];
    sb_full   = mdu_op_D_i && (sb_count_q == CW'(MAX_OUT));
    stall     = ld_hit || (ld_cnt_q != '0) || fwd_stall || sb_raw || sb_waw || sb_full;
  end

  always_comb begin
    stallF_o   = rst_ni && stall && !pc_takenE_i;
    stallD_o   = rst_ni && stall && !pc_takenE_i;
    flushD_o   = rst_ni && pc_takenE_i;
    flushE_o   = rst_ni && (stall || pc_takenE_i);
    forward_o  = rst_ni ? fwd_sel : '0;
    sb_busy_o  = rst_ni && (sb_count_q != '0);
    sb_count_o = rst_ni ? sb_count_q : '0;
  end

  // Done clears before issue sets, so a same-index issue wins.
  always_comb begin
    pending_nxt = pending_q;
    if (mdu_done_i) pending_nxt[mdu_done_rd_i] = 1'b0;
    if (mdu_issue_i && (mdu_rd_i != '0)) pending_nxt[mdu_rd_i] = 1'b1;
    pending_nxt[0] = 1'b0;
    sb_count_nxt = sb_count_q;
    if (mdu_issue_i && !mdu_done_i && (sb_count_q != CW'(MAX_OUT)))
      sb_count_nxt = sb_count_q + 1'b1;
    else if (mdu_done_i && !mdu_issue_i && (sb_count_q != '0))
      sb_count_nxt = sb_count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q  <= '0;
      sb_count_q <= '0;
      ld_cnt_q   <= '0;
    end else begin
      pending_q  <= pending_nxt;
      sb_count_q <= sb_count_nxt;
      if (pc_takenE_i)
        ld_cnt_q <= '0;
      else if (ld_hit)
        ld_cnt_q <= LW'(LOAD_LAT - 1);
      else if (ld_cnt_q != '0)
        ld_cnt_q <= ld_cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: three configurations (default, LOAD_LAT=3, FWD_EN=0)
// share one stimulus stream and are compared each cycle against a rule-level model.
module tb_hazard_scoreboard_unit;
  localparam int NRS = 2;
  localparam int AW  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NRS*AW-1:0] rs_d, rs_ex;
  logic [NRS-1:0]    rs_used;
  logic [AW-1:0]     rd_d, rd_ex, rd_mem, rd_wb, mdu_rd, mdu_done_rd;
  logic              regwrite_d, mdu_op_d, regwrite_ex, is_load_ex, regwrite_mem, regwrite_wb;
  logic              taken, mdu_issue, mdu_done;

  logic              sf[3], sd[3], fd[3], fe[3], busy[3];
  logic [NRS*2-1:0]  fw[3];
  logic [2:0]        cnt[3];

  hazard_scoreboard_unit #(.LOAD_LAT(1), .FWD_EN(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rs_D_i(rs_d), .rs_used_D_i(rs_used), .rd_D_i(rd_d),
    .regwrite_D_i(regwrite_d), .mdu_op_D_i(mdu_op_d), .rs_EX_i(rs_ex), .rd_EX_i(rd_ex),
    .regwrite_EX_i(regwrite_ex), .is_load_EX_i(is_load_ex), .rd_MEM_i(rd_mem),
    .regwrite_MEM_i(regwrite_mem), .rd_WB_i(rd_wb), .regwrite_WB_i(regwrite_wb),
    .pc_takenE_i(taken), .mdu_issue_i(mdu_issue), .mdu_rd_i(mdu_rd), .mdu_done_i(mdu_done),
    .mdu_done_rd_i(mdu_done_rd), .stallF_o(sf[0]), .stallD_o(sd[0]), .flushD_o(fd[0]),
    .flushE_o(fe[0]), .forward_o(fw[0]), .sb_busy_o(busy[0]), .sb_count_o(cnt[0]));

  hazard_scoreboard_unit #(.LOAD_LAT(3), .FWD_EN(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rs_D_i(rs_d), .rs_used_D_i(rs_used), .rd_D_i(rd_d),
    .regwrite_D_i(regwrite_d), .mdu_op_D_i(mdu_op_d), .rs_EX_i(rs_ex), .rd_EX_i(rd_ex),
    .regwrite_EX_i(regwrite_ex), .is_load_EX_i(is_load_ex), .rd_MEM_i(rd_mem),
    .regwrite_MEM_i(regwrite_mem), .rd_WB_i(rd_wb), .regwrite_WB_i(regwrite_wb),
    .pc_takenE_i(taken), .mdu_issue_i(mdu_issue), .mdu_rd_i(mdu_rd), .mdu_done_i(mdu_done),
    .mdu_done_rd_i(mdu_done_rd), .stallF_o(sf[1]), .stallD_o(sd[1]), .flushD_o(fd[1]),
    .flushE_o(fe[1]), .forward_o(fw[1]), .sb_busy_o(busy[1]), .sb_count_o(cnt[1]));

  hazard_scoreboard_unit #(.LOAD_LAT(1), .FWD_EN(0)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .rs_D_i(rs_d), .rs_used_D_i(rs_used), .rd_D_i(rd_d),
    .regwrite_D_i(regwrite_d), .mdu_op_D_i(mdu_op_d), .rs_EX_i(rs_ex), .rd_EX_i(rd_ex),
    .regwrite_EX_i(regwrite_ex), .is_load_EX_i(is_load_ex), .rd_MEM_i(rd_mem),
    .regwrite_MEM_i(regwrite_mem), .rd_WB_i(rd_wb), .regwrite_WB_i(regwrite_wb),
    .pc_takenE_i(taken), .mdu_issue_i(mdu_issue), .mdu_rd_i(mdu_rd), .mdu_done_i(mdu_done),
    .mdu_done_rd_i(mdu_done_rd), .stallF_o(sf[2]), .stallD_o(sd[2]), .flushD_o(fd[2]),
    .flushE_o(fe[2]), .forward_o(fw[2]), .sb_busy_o(busy[2]), .sb_count_o(cnt[2]));

  int checks = 0;
  int failures = 0;

  // Reference state: which registers await an MDU result, ops in flight, extra load bubbles.
  bit   pend[32];
  int   m_cnt;
  int   rem_b;
  int   q[$];

  logic [3:0]       s_ctl[3];
  logic [NRS*2-1:0] s_fw[3];
  logic [3:0]       s_bc[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rsd(input int k);
    return int'(rs_d[k*AW +: AW]);
  endfunction

  function automatic bit d_reads(input int r);
    bit hit = 0;
    if (r == 0) return 0;
    for (int k = 0; k < NRS; k++) if (rs_used[k] && rsd(k) == r) hit = 1;
    return hit;
  endfunction

  function automatic bit ld_hit_m();
    return is_load_ex && regwrite_ex && d_reads(int'(rd_ex));
  endfunction

  function automatic logic [3:0] exp_ctl(input int rem, input bit fen);
    bit st;
    st = (rem > 0) || ld_hit_m() || (regwrite_d && rd_d != 0 && pend[rd_d]) ||
         (mdu_op_d && m_cnt == 4);
    for (int k = 0; k < NRS; k++) if (rs_used[k] && pend[rsd(k)]) st = 1;
    if (!fen) st = st || (regwrite_ex && d_reads(int'(rd_ex))) || (regwrite_mem && d_reads(int'(rd_mem)));
    return {st && !taken, st && !taken, taken, st || taken};
  endfunction

  function automatic logic [NRS*2-1:0] exp_fwd(input bit fen);
    logic [NRS*2-1:0] v = '0;
    int r;
    if (!fen) return v;
    for (int k = 0; k < NRS; k++) begin
      r = int'(rs_ex[k*AW +: AW]);
      if (regwrite_mem && rd_mem != 0 && int'(rd_mem) == r)     v[2*k +: 2] = 2'b10;
      else if (regwrite_wb && rd_wb != 0 && int'(rd_wb) == r)   v[2*k +: 2] = 2'b01;
    end
    return v;
  endfunction

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 0;
    m_cnt = 0;
    rem_b = 0;
    q.delete();
  endtask

  task automatic model_update();
    bit h;
    h = ld_hit_m();
    if (mdu_done) pend[mdu_done_rd] = 0;
    if (mdu_issue && mdu_rd != 0) pend[mdu_rd] = 1;
    if (mdu_issue && !mdu_done && m_cnt < 4) m_cnt++;
    else if (mdu_done && !mdu_issue && m_cnt > 0) m_cnt--;
    if (mdu_done && q.size() > 0) void'(q.pop_front());
    if (mdu_issue) q.push_back(int'(mdu_rd));
    if (taken) rem_b = 0;
    else if (h) rem_b = 2;
    else if (rem_b > 0) rem_b--;
  endtask

  // Inputs are set just after a rising edge; outputs are sampled mid-cycle, model steps at the edge.
  task automatic step();
    logic [3:0] bc;
    #3;
    if (!rst_n) model_reset();
    bc = {m_cnt != 0, 3'(m_cnt)};
    for (int i = 0; i < 3; i++) begin
      s_ctl[i] = {sf[i], sd[i], fd[i], fe[i]};
      s_fw[i]  = fw[i];
      s_bc[i]  = {busy[i], cnt[i]};
      check($sformatf("ctl%0d", i), s_ctl[i], rst_n ? exp_ctl(i == 1 ? rem_b : 0, i != 2) : 4'b0);
      check($sformatf("fwd%0d", i), s_fw[i], rst_n ? exp_fwd(i != 2) : '0);
      check($sformatf("sb%0d", i),  s_bc[i], rst_n ? bc : 4'b0);
    end
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic clear_in();
    rs_d = '0; rs_ex = '0; rs_used = '0; rd_d = '0; rd_ex = '0; rd_mem = '0; rd_wb = '0;
    mdu_rd = '0; mdu_done_rd = '0; regwrite_d = 0; mdu_op_d = 0; regwrite_ex = 0;
    is_load_ex = 0; regwrite_mem = 0; regwrite_wb = 0; taken = 0; mdu_issue = 0; mdu_done = 0;
  endtask

  task automatic load_use_pair();
    clear_in();
    is_load_ex = 1; regwrite_ex = 1; rd_ex = 5'd5;
    rs_d = {5'd1, 5'd5}; rs_used = 2'b11; regwrite_d = 1; rd_d = 5'd6;
  endtask

  logic [4:0] pat_sf, pat_fe;

  initial begin
    rst_n = 0;
    clear_in();
    model_reset();
    @(posedge clk); #1;
    step();
    check("reset_ctl", s_ctl[0], 4'b0);
    rst_n = 1;
    step();

    // Load-use with LOAD_LAT=1, then forwarding from MEM.
    load_use_pair();
    step();
    check("lu_stall", s_ctl[0], 4'b1101);
    clear_in();
    regwrite_mem = 1; rd_mem = 5'd5; rs_ex = {5'd1, 5'd5};
    step();
    check("lu_fwd", s_fw[0][1:0], 2'b10);
    check("lu_release", s_ctl[0], 4'b0);
    clear_in();
    step(); step();

    // LOAD_LAT=3: exactly three consecutive bubbles.
    pat_sf = '0;
    load_use_pair();
    for (int c = 0; c < 5; c++) begin
      step();
      pat_sf = {pat_sf[3:0], s_ctl[1][3]};
      is_load_ex = 0; regwrite_ex = 0; rd_ex = '0;
    end
    check("lat3_bubbles", pat_sf, 5'b11100);

    // LOAD_LAT=3 cut short by a taken branch in the second stall cycle.
    pat_sf = '0; pat_fe = '0;
    load_use_pair();
    for (int c = 0; c < 4; c++) begin
      taken = (c == 1);
      step();
      pat_sf = {pat_sf[3:0], s_ctl[1][3]};
      pat_fe = {pat_fe[3:0], s_ctl[1][0]};
      is_load_ex = 0; regwrite_ex = 0; rd_ex = '0;
    end
    check("lat3_br_stall", pat_sf[3:0], 4'b1000);
    check("lat3_br_flushE", pat_fe[3:0], 4'b1100);

    // MEM priority over WB; FWD_EN=0 stalls instead.
    clear_in();
    regwrite_mem = 1; rd_mem = 5'd7; regwrite_wb = 1; rd_wb = 5'd7; rs_ex = {5'd7, 5'd7};
    rs_d = {5'd0, 5'd7}; rs_used = 2'b01;
    step();
    check("fwd_mem_prio", s_fw[0], 4'b1010);
    check("fwd_off", s_fw[2], 4'b0000);
    check("nofwd_stall", s_ctl[2], 4'b1101);
    rd_mem = '0; rd_wb = '0; rs_ex = '0; rs_d = '0; rs_used = 2'b11; regwrite_ex = 1;
    step();
    check("x0_fwd", s_fw[0], 4'b0);
    check("x0_nostall", s_ctl[2], 4'b0);

    // Scoreboard RAW on x9 until the MDU completes.
    clear_in();
    mdu_issue = 1; mdu_rd = 5'd9;
    step();
    clear_in();
    rs_d = {5'd0, 5'd9}; rs_used = 2'b01;
    for (int c = 0; c < 3; c++) begin
      step();
      check("raw_hold", s_ctl[0], 4'b1101);
    end
    mdu_done = 1; mdu_done_rd = 5'd9;
    step();
    check("raw_done_cycle", s_ctl[0], 4'b1101);
    mdu_done = 0;
    step();
    check("raw_release", s_ctl[0], 4'b0);

    // Fill the MDU, stall a further MDU op, drain one.
    clear_in();
    for (int c = 0; c < 4; c++) begin
      mdu_issue = 1; mdu_rd = 5'(10 + c);
      step();
    end
    clear_in();
    mdu_op_d = 1;
    step();
    check("full_stall", s_ctl[0], 4'b1101);
    check("full_count", s_bc[0], 4'b1100);
    mdu_done = 1; mdu_done_rd = 5'd10;
    step();
    mdu_done = 0;
    step();
    check("drain_count", s_bc[0], 4'b1011);
    check("drain_release", s_ctl[0], 4'b0);

    // Reset in the middle of a scoreboard stall.
    clear_in();
    rs_d = {5'd0, 5'd11}; rs_used = 2'b01;
    step();
    check("pre_rst_stall", s_ctl[0], 4'b1101);
    rst_n = 0;
    step();
    check("rst_now", s_ctl[0], 4'b0);
    rst_n = 1;
    step();
    check("rst_after_busy", s_bc[0], 4'b0);
    check("rst_after_ctl", s_ctl[0], 4'b0);

    // Randomised traffic over a small register window to provoke collisions.
    for (int n = 0; n < 2000; n++) begin
      rst_n       = ($urandom_range(199) != 0);
      rs_d        = {5'($urandom_range(7)), 5'($urandom_range(7))};
      rs_ex       = {5'($urandom_range(7)), 5'($urandom_range(7))};
      rs_used     = 2'($urandom_range(3));
      rd_d        = 5'($urandom_range(7));
      rd_ex       = 5'($urandom_range(7));
      rd_mem      = 5'($urandom_range(7));
      rd_wb       = 5'($urandom_range(7));
      regwrite_d  = 1'($urandom_range(1));
      mdu_op_d    = 1'($urandom_range(1));
      regwrite_ex = 1'($urandom_range(1));
      is_load_ex  = ($urandom_range(2) == 0);
      regwrite_mem = 1'($urandom_range(1));
      regwrite_wb = 1'($urandom_range(1));
      taken       = ($urandom_range(7) == 0);
      mdu_issue   = (q.size() < 4) && ($urandom_range(3) == 0);
      mdu_rd      = 5'($urandom_range(7));
      mdu_done    = (q.size() > 0) && ($urandom_range(3) == 0);
      mdu_done_rd = (q.size() > 0) ? 5'(q[0]) : 5'd0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
